// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Contents:
//   fetch_state_t   - fetch FSM state encoding (IDLE, WAIT, DROP)
//   INSTR_WIDTH     - native instruction/address width
//   PC_INCREMENT    - byte distance between consecutive instruction words
//   queue_has_room  - issue gating helper for the instruction queue
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int INSTR_WIDTH  = 32;
    localparam int PC_INCREMENT = 4;

    // A request may only be issued when its response is guaranteed a slot.
    // Only one request is ever outstanding, so one free slot (counting an
    // entry leaving this very cycle as free) is enough.
    function automatic logic queue_has_room(input logic [1:0] count,
                                            input logic       popping,
                                            input int         depth);
        return (int'(count) < depth) || popping;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue_2.sv
// fetch_queue_2: two-entry FIFO of {PC, instruction} pairs.
// Ports:
//   Clock, Reset        - rising-edge clock, asynchronous active-high reset
//   flush               - empties the queue (dominates push and pop)
//   push, push_pc,
//   push_data           - write a new entry at the tail
//   pop                 - remove the head entry (ignored when empty)
//   valid               - queue holds at least one entry
//   count               - number of entries held (0..2)
//   head_pc, head_data  - registered head entry
module fetch_queue_2 #(
    parameter int Width = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] push_pc,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [1:0]       count,
    output logic [Width-1:0] head_pc,
    output logic [Width-1:0] head_data
);

    logic [Width-1:0] tail_pc;
    logic [Width-1:0] tail_data;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);
    assign valid   = (count != 2'd0);

    // The head lives in its own register pair so decode sees a registered
    // value. A pop shifts the tail into the head; a push lands in the head
    // when it would become the only entry, otherwise in the tail.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count     <= 2'd0;
            head_pc   <= '0;
            head_data <= '0;
            tail_pc   <= '0;
            tail_data <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b01: begin
                    head_pc   <= tail_pc;
                    head_data <= tail_data;
                    count     <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc   <= push_pc;
                        head_data <= push_data;
                    end else begin
                        tail_pc   <= push_pc;
                        tail_data <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_pc   <= push_pc;
                        head_data <= push_data;
                    end else begin
                        head_pc   <= tail_pc;
                        head_data <= tail_data;
                        tail_pc   <= push_pc;
                        tail_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, reads instruction words from memory
// over a req/ack handshake (one request outstanding at most) and hands them
// to decode with their PC through a two-entry queue (valid/ready).
// A redirect from execute flushes queued and in-flight work.
// Ports:
//   Clock, Reset            - rising-edge clock, asynchronous active-high reset
//   Redirect, RedirectPC    - load a new fetch PC, flush everything
//   ImemReq, ImemAddr       - registered read request and byte address
//   ImemAck, ImemData       - read response
//   InstrValid, InstrReady  - decode handshake
//   InstrData, InstrPC      - queue head
//   MisalignErr             - only when FETCH_MISALIGN_CHECK_EN is defined:
//                             a misaligned redirect target halts fetching
//                             until the next aligned redirect
// Build option: FETCH_MISALIGN_CHECK_EN
module instr_fetch_unit #(
    parameter int                  NrOfBits    = instr_fetch_unit_pkg::INSTR_WIDTH,
    parameter logic [NrOfBits-1:0] ResetVector = '0,
    parameter int                  QueueDepth  = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Redirect,
    input  logic [NrOfBits-1:0] RedirectPC,
    output logic                ImemReq,
    output logic [NrOfBits-1:0] ImemAddr,
    input  logic                ImemAck,
    input  logic [NrOfBits-1:0] ImemData,
    output logic                InstrValid,
    input  logic                InstrReady,
    output logic [NrOfBits-1:0] InstrData,
    output logic [NrOfBits-1:0] InstrPC
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                MisalignErr
`endif
);

    import instr_fetch_unit_pkg::*;

    fetch_state_t        state;
    logic [NrOfBits-1:0] fetch_pc;
    logic [NrOfBits-1:0] redirect_target;
    logic [1:0]          count;
    logic                push;
    logic                issue;
    logic                blocked;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;
    logic misalign_err;

    assign redirect_target = RedirectPC;
    assign misaligned      = (RedirectPC[1:0] != 2'b00);
    assign blocked         = misalign_err;
    assign MisalignErr     = misalign_err;

    // Each redirect re-evaluates the alignment of its target; the error
    // flag stays set (and fetching stays halted) until an aligned one.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            misalign_err <= 1'b0;
        end else if (Redirect) begin
            misalign_err <= misaligned;
        end
    end
`else
    assign redirect_target = RedirectPC & ~NrOfBits'(3);
    assign blocked         = 1'b0;
`endif

    // Only a response to a live request in WAIT is queued; a response that
    // coincides with a redirect belongs to the old stream.
    assign push  = (state == WAIT) && ImemAck && !Redirect;
    assign issue = (state == IDLE) && !Redirect && !blocked &&
                   queue_has_room(count, InstrValid && InstrReady, QueueDepth);

    // Fetch FSM with registered request outputs. Redirect has priority in
    // every state; a request already on the bus is never withdrawn, so a
    // redirect without a coincident ack parks in DROP until the stale ack.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            fetch_pc <= ResetVector;
            ImemReq  <= 1'b0;
            ImemAddr <= '0;
        end else if (Redirect) begin
            fetch_pc <= redirect_target;
            case (state)
                WAIT: begin
                    if (ImemAck) begin
                        state   <= IDLE;
                        ImemReq <= 1'b0;
                    end else begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (ImemAck) begin
                        state   <= IDLE;
                        ImemReq <= 1'b0;
                    end
                end
                default: ;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        ImemReq  <= 1'b1;
                        ImemAddr <= fetch_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (ImemAck) begin
                        fetch_pc <= fetch_pc + NrOfBits'(PC_INCREMENT);
                        ImemReq  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DROP: begin
                    if (ImemAck) begin
                        ImemReq <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    ImemReq <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    fetch_queue_2 #(
        .Width(NrOfBits)
    ) queue (
        .Clock    (Clock),
        .Reset    (Reset),
        .flush    (Redirect),
        .push     (push),
        .push_pc  (ImemAddr),
        .push_data(ImemData),
        .pop      (InstrValid && InstrReady),
        .valid    (InstrValid),
        .count    (count),
        .head_pc  (InstrPC),
        .head_data(InstrData)
    );

endmodule
